// File: rtl/store_merge_unit_if.sv
// Store merge unit bus: the pipeline request and status signals together with the word-wide data memory port.
// Pure signal bundle; it has no storage and adds no latency.
// The pipeline side watches busy and the memory side has no backpressure.
interface store_merge_unit_if;
  logic        start;
  logic [2:0]  store_mode;
  logic [31:0] addr;
  logic [31:0] store_value;
  logic        busy;
  logic        done;
  logic        align_error;
  logic [31:0] mem_addr;
  logic        mem_rd_en;
  logic [31:0] mem_rd_data;
  logic        mem_wr_en;
  logic [31:0] mem_wr_data;

  // Unit side: takes requests and read data, drives status and memory strobes.
  modport slave (
    input  start, store_mode, addr, store_value, mem_rd_data,
    output busy, done, align_error, mem_addr, mem_rd_en, mem_wr_en, mem_wr_data
  );

  // Pipeline/memory side: the mirror image of the unit side.
  modport master (
    output start, store_mode, addr, store_value, mem_rd_data,
    input  busy, done, align_error, mem_addr, mem_rd_en, mem_wr_en, mem_wr_data
  );
endinterface

// File: rtl/store_merge_unit.sv
// Writes SW/SH/SB stores into word-wide memory; byte and halfword stores go through a read-modify-write.
// Latency: a word store writes 1 cycle after acceptance; a byte or halfword store writes 3 cycles after acceptance.
// busy stalls the pipeline and start is ignored outside IDLE; a misaligned request only pulses align_error.
module store_merge_unit (
  input  logic               clk,
  input  logic               rst_n,
  store_merge_unit_if.slave  smu_if
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_MERGE = 2'd2,
    ST_WRITE = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  mode_q, mode_d;
  logic [31:0] addr_q, addr_d;
  // Holds the latched store value until MERGE, then holds the merged word.
  logic [31:0] data_q, data_d;
  logic        align_err_q, align_err_d;

  logic        req_byte;
  logic        req_half;
  logic        req_misaligned;
  logic        lat_byte;
  logic        lat_half;
  logic [31:0] merged;

  // Classify the incoming request; byte stores can never be misaligned.
  always_comb begin
    req_byte       = (smu_if.store_mode == 3'd1);
    req_half       = (smu_if.store_mode == 3'd2);
    req_misaligned = 1'b0;
    if (req_half) begin
      req_misaligned = smu_if.addr[0];
    end else if (!req_byte) begin
      req_misaligned = (smu_if.addr[1:0] != 2'b00);
    end
  end

  // Replace the addressed lane of the read word; every other bit passes through untouched.
  always_comb begin
    lat_byte = (mode_q == 3'd1);
    lat_half = (mode_q == 3'd2);
    merged   = smu_if.mem_rd_data;
    if (lat_byte) begin
      case (addr_q[1:0])
        2'd0:    merged[7:0]   = data_q[7:0];
        2'd1:    merged[15:8]  = data_q[7:0];
        2'd2:    merged[23:16] = data_q[7:0];
        default: merged[31:24] = data_q[7:0];
      endcase
    end else if (lat_half) begin
      if (addr_q[1]) begin
        merged[31:16] = data_q[15:0];
      end else begin
        merged[15:0]  = data_q[15:0];
      end
    end
  end

  // Next-state logic: accept in IDLE, then READ -> MERGE -> WRITE for sub-word stores.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    addr_d      = addr_q;
    data_d      = data_q;
    align_err_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (smu_if.start) begin
          if (req_misaligned) begin
            align_err_d = 1'b1;
          end else begin
            mode_d  = smu_if.store_mode;
            addr_d  = smu_if.addr;
            data_d  = smu_if.store_value;
            state_d = (req_byte || req_half) ? ST_READ : ST_WRITE;
          end
        end
      end
      ST_READ: begin
        state_d = ST_MERGE;
      end
      ST_MERGE: begin
        data_d  = merged;
        state_d = ST_WRITE;
      end
      ST_WRITE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and latched request; reset aborts any request in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      mode_q      <= 3'd0;
      addr_q      <= 32'd0;
      data_q      <= 32'd0;
      align_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      align_err_q <= align_err_d;
    end
  end

  // Outputs are decoded from registered state only, so no input reaches an output in the same cycle.
  assign smu_if.busy        = (state_q != ST_IDLE);
  assign smu_if.done        = (state_q == ST_WRITE);
  assign smu_if.align_error = align_err_q;
  assign smu_if.mem_addr    = {addr_q[31:2], 2'b00};
  assign smu_if.mem_rd_en   = (state_q == ST_READ);
  assign smu_if.mem_wr_en   = (state_q == ST_WRITE);
  assign smu_if.mem_wr_data = data_q;

endmodule

// File: tb/tb_store_merge_unit.sv
// Self-checking bench for store_merge_unit with a behavioural memory and a store reference model.
// Latency: the bench drives inputs 1 time unit after each rising edge and samples outputs at that same point.
// Backpressure: each request waits for busy to drop before it is issued.
module tb_store_merge_unit;

  logic clk = 1'b0;
  logic rst_n;
  store_merge_unit_if smu_if ();

  store_merge_unit dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .smu_if (smu_if.slave)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int wr_total = 0;
  int done_total = 0;
  int overlap_total = 0;

  logic [31:0] mem [0:255];

  // Synchronous-read memory with a 1-cycle read.
  always @(posedge clk) begin
    if (smu_if.mem_rd_en) smu_if.mem_rd_data <= mem[smu_if.mem_addr[9:2]];
    if (smu_if.mem_wr_en) mem[smu_if.mem_addr[9:2]] = smu_if.mem_wr_data;
  end

  // Event counters, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n && smu_if.mem_wr_en) wr_total++;
    if (rst_n && smu_if.done) done_total++;
    if (smu_if.mem_rd_en && smu_if.mem_wr_en) overlap_total++;
  end

  // Results captured by the most recent issue() call.
  int          r_lat, r_nrd, r_nwr, r_nerr, r_nbusy;
  logic [31:0] r_waddr, r_wdata;

  // Reference model: byte/halfword/word store rules written with masks and shifts.
  function automatic logic model_misaligned(input logic [2:0] m, input logic [31:0] a);
    if (m == 3'd1) return 1'b0;
    if (m == 3'd2) return a[0];
    return (a[1:0] != 2'b00);
  endfunction

  function automatic logic [31:0] model_store(input logic [2:0] m, input logic [31:0] a,
                                              input logic [31:0] v, input logic [31:0] old);
    int          sh;
    logic [31:0] mask;
    if (m == 3'd1) begin
      sh   = 8 * int'(a[1:0]);
      mask = 32'h0000_00FF << sh;
      return (old & ~mask) | ((v & 32'h0000_00FF) << sh);
    end
    if (m == 3'd2) begin
      sh   = 16 * int'(a[1]);
      mask = 32'h0000_FFFF << sh;
      return (old & ~mask) | ((v & 32'h0000_FFFF) << sh);
    end
    return v;
  endfunction

  function automatic int model_latency(input logic [2:0] m);
    return (m == 3'd1 || m == 3'd2) ? 3 : 1;
  endfunction

  task automatic randomize_inputs();
    smu_if.store_mode  = 3'($urandom_range(0, 7));
    smu_if.addr        = $urandom;
    smu_if.store_value = $urandom;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 10 && smu_if.busy; i++) begin
      @(posedge clk); #1;
    end
  endtask

  // Issues one request, then observes up to 8 cycles (stops at done). The caller does the checking.
  task automatic issue(input logic [2:0] m, input logic [31:0] a, input logic [31:0] v);
    r_lat = 0; r_nrd = 0; r_nwr = 0; r_nerr = 0; r_nbusy = 0;
    r_waddr = 32'd0; r_wdata = 32'd0;
    wait_idle();
    smu_if.start = 1'b1; smu_if.store_mode = m; smu_if.addr = a; smu_if.store_value = v;
    @(posedge clk); #1;
    smu_if.start = 1'b0;
    randomize_inputs();
    for (int c = 1; c <= 8; c++) begin
      if (smu_if.busy) r_nbusy++;
      if (smu_if.mem_rd_en) r_nrd++;
      if (smu_if.align_error) r_nerr++;
      if (smu_if.mem_wr_en) begin
        r_nwr++;
        r_waddr = smu_if.mem_addr;
        r_wdata = smu_if.mem_wr_data;
      end
      if (smu_if.done) begin
        r_lat = c;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    logic [68:0] outs;
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      smu_if.start = 1'($urandom);
      randomize_inputs();
      smu_if.mem_rd_data = $urandom;
      @(posedge clk); #1;
      outs = {smu_if.busy, smu_if.done, smu_if.align_error, smu_if.mem_rd_en, smu_if.mem_wr_en,
              smu_if.mem_addr, smu_if.mem_wr_data};
      checks++;
      if (outs !== 69'd0) begin errors++; $display("FAIL reset_outputs cyc%0d: got %h expected 0", i, outs); end
    end
    smu_if.start = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (smu_if.busy !== 1'b0) begin errors++; $display("FAIL reset_release_busy: got %b expected 0", smu_if.busy); end
  endtask

  task automatic test_reset_mid_merge();
    int wr0, done0;
    wait_idle();
    mem[8'h0C] = 32'h5566_7788;
    wr0 = wr_total; done0 = done_total;
    smu_if.start = 1'b1; smu_if.store_mode = 3'd1; smu_if.addr = 32'h30; smu_if.store_value = 32'h99;
    @(posedge clk); #1;   // READ
    smu_if.start = 1'b0;
    @(posedge clk); #1;   // MERGE
    checks++;
    if (smu_if.busy !== 1'b1) begin errors++; $display("FAIL mid_reset_in_merge_busy: got %b expected 1", smu_if.busy); end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({smu_if.busy, smu_if.mem_wr_en, smu_if.done, smu_if.mem_addr, smu_if.mem_wr_data} !== 67'd0) begin
      errors++;
      $display("FAIL mid_reset_async: busy=%b wr=%b done=%b addr=%h wdat=%h expected all 0",
               smu_if.busy, smu_if.mem_wr_en, smu_if.done, smu_if.mem_addr, smu_if.mem_wr_data);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin @(posedge clk); #1; end
    checks++;
    if (wr_total - wr0 !== 0) begin errors++; $display("FAIL mid_reset_no_write: got %0d writes expected 0", wr_total - wr0); end
    checks++;
    if (done_total - done0 !== 0) begin errors++; $display("FAIL mid_reset_no_done: got %0d expected 0", done_total - done0); end
    checks++;
    if (mem[8'h0C] !== 32'h5566_7788) begin errors++; $display("FAIL mid_reset_mem: got %h expected 55667788", mem[8'h0C]); end
  endtask

  task automatic test_word();
    issue(3'd0, 32'h0000_0010, 32'hDEAD_BEEF);
    checks++;
    if (r_lat !== 1) begin errors++; $display("FAIL word_latency: got %0d expected 1", r_lat); end
    checks++;
    if (r_waddr !== 32'h10) begin errors++; $display("FAIL word_addr: got %h expected 00000010", r_waddr); end
    checks++;
    if (r_wdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL word_data: got %h expected deadbeef", r_wdata); end
    checks++;
    if (r_nrd !== 0 || r_nwr !== 1 || r_nbusy !== 1) begin
      errors++; $display("FAIL word_strobes: rd=%0d wr=%0d busy=%0d expected 0 1 1", r_nrd, r_nwr, r_nbusy);
    end
  endtask

  task automatic test_byte_lanes();
    logic [31:0] exp_tab [4];
    exp_tab = '{32'h1122_33AB, 32'h1122_AB44, 32'h11AB_3344, 32'hAB22_3344};
    for (int l = 0; l < 4; l++) begin
      wait_idle();
      mem[8'h08] = 32'h1122_3344;
      issue(3'd1, 32'h20 + 32'(l), 32'hFFFF_FFAB);
      checks++;
      if (r_lat !== 3 || r_nrd !== 1 || r_nwr !== 1 || r_nbusy !== 3) begin
        errors++; $display("FAIL byte_lane%0d_timing: lat=%0d rd=%0d wr=%0d busy=%0d expected 3 1 1 3", l, r_lat, r_nrd, r_nwr, r_nbusy);
      end
      checks++;
      if (r_wdata !== exp_tab[l] || r_waddr !== 32'h20) begin
        errors++; $display("FAIL byte_lane%0d_data: got %h@%h expected %h@00000020", l, r_wdata, r_waddr, exp_tab[l]);
      end
    end
  endtask

  task automatic test_half();
    wait_idle();
    mem[8'h10] = 32'hAAAA_BBBB;
    issue(3'd2, 32'h42, 32'h0000_1234);
    checks++;
    if (r_waddr !== 32'h40 || r_wdata !== 32'h1234_BBBB || r_lat !== 3) begin
      errors++; $display("FAIL half_upper: got %h@%h lat %0d expected 1234bbbb@00000040 lat 3", r_wdata, r_waddr, r_lat);
    end
    wait_idle();
    mem[8'h10] = 32'hAAAA_BBBB;
    issue(3'd2, 32'h40, 32'h0000_1234);
    checks++;
    if (r_waddr !== 32'h40 || r_wdata !== 32'hAAAA_1234 || r_lat !== 3) begin
      errors++; $display("FAIL half_lower: got %h@%h lat %0d expected aaaa1234@00000040 lat 3", r_wdata, r_waddr, r_lat);
    end
  endtask

  task automatic test_misalign();
    logic [2:0]  modes [3];
    logic [31:0] addrs [3];
    modes = '{3'd2, 3'd0, 3'd6};
    addrs = '{32'h41, 32'h42, 32'h47};
    for (int i = 0; i < 3; i++) begin
      issue(modes[i], addrs[i], $urandom);
      checks++;
      if (r_nerr !== 1 || r_nrd !== 0 || r_nwr !== 0 || r_lat !== 0 || r_nbusy !== 0) begin
        errors++;
        $display("FAIL misalign_%0d: err=%0d rd=%0d wr=%0d done_lat=%0d busy=%0d expected 1 0 0 0 0",
                 i, r_nerr, r_nrd, r_nwr, r_lat, r_nbusy);
      end
    end
    issue(3'd5, 32'h44, 32'h0BAD_F00D);
    checks++;
    if (r_lat !== 1 || r_nrd !== 0 || r_wdata !== 32'h0BAD_F00D || r_waddr !== 32'h44 || r_nerr !== 0) begin
      errors++; $display("FAIL mode5_word: got %h@%h lat %0d rd %0d expected 0badf00d@00000044 lat 1 rd 0", r_wdata, r_waddr, r_lat, r_nrd);
    end
  endtask

  task automatic test_random();
    logic [2:0]  m;
    logic [31:0] a, v, old, expw;
    for (int n = 0; n < 40; n++) begin
      wait_idle();
      m   = 3'($urandom_range(0, 7));
      a   = 32'($urandom_range(0, 1023));
      v   = $urandom;
      old = mem[a[9:2]];
      issue(m, a, v);
      checks++;
      if (model_misaligned(m, a)) begin
        if (r_nerr !== 1 || r_nwr !== 0 || r_nrd !== 0 || r_lat !== 0) begin
          errors++; $display("FAIL rand%0d_misalign m=%0d a=%h: err=%0d wr=%0d rd=%0d lat=%0d", n, m, a, r_nerr, r_nwr, r_nrd, r_lat);
        end
      end else begin
        expw = model_store(m, a, v, old);
        if (r_wdata !== expw || r_waddr !== {a[31:2], 2'b00} || r_lat !== model_latency(m) || r_nwr !== 1) begin
          errors++;
          $display("FAIL rand%0d_store m=%0d a=%h: got %h@%h lat %0d expected %h@%h lat %0d",
                   n, m, a, r_wdata, r_waddr, r_lat, expw, {a[31:2], 2'b00}, model_latency(m));
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] vals [12];
    wait_idle();
    smu_if.start = 1'b1; smu_if.store_mode = 3'd0; smu_if.addr = 32'h80;
    for (int k = 0; k < 12; k++) begin
      vals[k] = $urandom;
      smu_if.store_value = vals[k];
      @(posedge clk); #1;
      checks++;
      if (smu_if.mem_wr_en !== 1'((k + 1) % 2)) begin
        errors++; $display("FAIL b2b_wr_cyc%0d: got %b expected %0d", k + 1, smu_if.mem_wr_en, (k + 1) % 2);
      end else if (smu_if.mem_wr_en && smu_if.mem_wr_data !== vals[k]) begin
        errors++; $display("FAIL b2b_data_cyc%0d: got %h expected %h", k + 1, smu_if.mem_wr_data, vals[k]);
      end
    end
    smu_if.start = 1'b0;
  endtask

  task automatic test_ignore_mid_start();
    int          wr0;
    logic [31:0] old, v;
    wait_idle();
    @(posedge clk); #1;
    old = mem[8'h09];
    v   = $urandom;
    wr0 = wr_total;
    smu_if.start = 1'b1; smu_if.store_mode = 3'd1; smu_if.addr = 32'h25; smu_if.store_value = v;
    @(posedge clk); #1;   // READ: pulse a competing word store
    smu_if.start = 1'b1; smu_if.store_mode = 3'd0; smu_if.addr = 32'h100; smu_if.store_value = $urandom;
    @(posedge clk); #1;
    smu_if.start = 1'b0;
    for (int i = 0; i < 6; i++) begin @(posedge clk); #1; end
    checks++;
    if (wr_total - wr0 !== 1) begin errors++; $display("FAIL mid_start_writes: got %0d expected 1", wr_total - wr0); end
    checks++;
    if (mem[8'h09] !== model_store(3'd1, 32'h25, v, old)) begin
      errors++; $display("FAIL mid_start_data: got %h expected %h", mem[8'h09], model_store(3'd1, 32'h25, v, old));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    smu_if.start = 1'b0;
    smu_if.store_mode = 3'd0;
    smu_if.addr = 32'd0;
    smu_if.store_value = 32'd0;
    test_reset();
    test_word();
    test_byte_lanes();
    test_half();
    test_misalign();
    test_random();
    test_back_to_back();
    test_ignore_mid_start();
    test_reset_mid_merge();
    checks++;
    if (overlap_total !== 0) begin errors++; $display("FAIL rd_wr_overlap: got %0d cycles expected 0", overlap_total); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
